// File: rtl/bfm_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency bfm datapath between
// NUM_REQ requesters. Every result comes back tagged with its requester index.
module bfm_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ITEM_WIDTH = 8,
  parameter int RES_LAT    = 1,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          hold_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ITEM_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*ITEM_WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [ITEM_WIDTH-1:0]         alu_a_o,
  output logic [ITEM_WIDTH-1:0]         alu_b_o,
  input  logic [ITEM_WIDTH-1:0]         alu_res_i,
  output logic                          rsp_valid_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [ITEM_WIDTH-1:0]         rsp_data_o,
  output logic [15:0]                   issue_cnt_o
);

  localparam int NSTG = RES_LAT + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } trk_t;

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ITEM_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [15:0]           issue_cnt_q, issue_cnt_d;
  trk_t                  stg_q [NSTG];
  trk_t                  stg_d [NSTG];
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [ITEM_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       cand;
  logic                  transfer;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_found   = 1'b0;
    gnt_id      = '0;
    cand        = '0;
    req_ready_o = '0;
    // Scan starts at ptr_q and wraps, so the first hit is the round-robin winner.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
    transfer = gnt_found && !hold_i && reset_ni;
    if (transfer) req_ready_o[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    issue_cnt_d = issue_cnt_q;
    if (transfer) begin
      ptr_d   = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
      alu_a_d = req_a_i[gnt_id*ITEM_WIDTH +: ITEM_WIDTH];
      alu_b_d = req_b_i[gnt_id*ITEM_WIDTH +: ITEM_WIDTH];
      if (issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
    end

    // Tracking pipeline never stalls; hold_i only suppresses new transfers.
    stg_d[0] = '{vld: transfer, id: gnt_id};
    for (int s = 1; s < NSTG; s++) stg_d[s] = stg_q[s-1];

    rsp_valid_d = stg_q[NSTG-1].vld;
    rsp_id_d    = stg_q[NSTG-1].id;
    rsp_data_d  = stg_q[NSTG-1].vld ? alu_res_i : rsp_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      issue_cnt_q <= '0;
      for (int s = 0; s < NSTG; s++) stg_q[s] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      issue_cnt_q <= issue_cnt_d;
      for (int s = 0; s < NSTG; s++) stg_q[s] <= stg_d[s];
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign issue_cnt_o = issue_cnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_bfm_arbiter.sv
// Self-checking bench for bfm_arbiter: a grant vector table plus a timed
// response scoreboard, with a registered adder standing in for bfm (RES_LAT=1).
module tb_bfm_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic            hold_i;
  logic [NR-1:0]   req_valid_i;
  logic [NR*W-1:0] req_a_i, req_b_i;
  logic [NR-1:0]   req_ready_o;
  logic [W-1:0]    alu_a_o, alu_b_o;
  logic [W-1:0]    bfm_res = '0;
  logic            rsp_valid_o;
  logic [1:0]      rsp_id_o;
  logic [W-1:0]    rsp_data_o;
  logic [15:0]     issue_cnt_o;

  bfm_arbiter #(.NUM_REQ(NR), .ITEM_WIDTH(W), .RES_LAT(1)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .hold_i     (hold_i),
    .req_valid_i(req_valid_i),
    .req_a_i    (req_a_i),
    .req_b_i    (req_b_i),
    .req_ready_o(req_ready_o),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .alu_res_i  (bfm_res),
    .rsp_valid_o(rsp_valid_o),
    .rsp_id_o   (rsp_id_o),
    .rsp_data_o (rsp_data_o),
    .issue_cnt_o(issue_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // bfm stand-in: one register stage after the operand registers.
  always @(posedge clk_i) bfm_res <= alu_a_o + alu_b_o;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic       hold;
    logic [3:0] valid;
    logic [7:0] a_base;
    logic [7:0] b;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         due;
  } exp_t;

  vec_t        vt[$];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_vec(input logic h, input logic [3:0] v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] er);
    vec_t e;
    e.hold = h; e.valid = v; e.a_base = a; e.b = b; e.exp_ready = er;
    vt.push_back(e);
  endtask

  // Requester k presents A = a_base + k, B = b. Ready is checked before the
  // edge; an expected transfer queues its result due RES_LAT+1 edges later.
  task automatic step(input logic h, input logic [3:0] v, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] er, input string name);
    exp_t e;
    @(negedge clk_i);
    hold_i      = h;
    req_valid_i = v;
    for (int k = 0; k < NR; k++) begin
      req_a_i[k*W +: W] = a + 8'(k);
      req_b_i[k*W +: W] = b;
    end
    #1;
    check({name, " ready"}, req_ready_o, er);
    check({name, " issue_cnt"}, issue_cnt_o, exp_cnt);
    if (er != 4'b0000) begin
      e.id = 2'd0;
      for (int k = 0; k < NR; k++) if (er[k]) e.id = 2'(k);
      e.data = a + 8'(e.id) + b;
      e.due  = cyc + 3;
      sb.push_back(e);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  // Response monitor: a result must appear exactly on its due cycle, never otherwise.
  always @(negedge clk_i) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("rsp_id", 32'(rsp_id_o), 32'(sb[0].id));
      check("rsp_data", 32'(rsp_data_o), 32'(sb[0].data));
      void'(sb.pop_front());
    end else begin
      check("rsp_idle", 32'(rsp_valid_o), 32'd0);
    end
  end

  initial begin
    reset_ni    = 1'b0;
    hold_i      = 1'b0;
    req_valid_i = 4'hF;
    req_a_i     = '0;
    req_b_i     = '0;

    // Full contention: A=k, B=10, strict 0..3 rotation, twice.
    for (int r = 0; r < 2; r++) begin
      add_vec(0, 4'hF, 8'd0, 8'd10, 4'b0001);
      add_vec(0, 4'hF, 8'd0, 8'd10, 4'b0010);
      add_vec(0, 4'hF, 8'd0, 8'd10, 4'b0100);
      add_vec(0, 4'hF, 8'd0, 8'd10, 4'b1000);
    end
    add_vec(0, 4'h0, 8'd0, 8'd0, 4'b0000);
    add_vec(0, 4'h0, 8'd0, 8'd0, 4'b0000);
    // Lone requester 2 with A=3, B=5 -> 8.
    add_vec(0, 4'b0100, 8'd1, 8'd5, 4'b0100);
    for (int i = 0; i < 3; i++) add_vec(0, 4'h0, 8'd0, 8'd0, 4'b0000);
    // Lone requesters win regardless of ptr (ptr=3 here, then 3, then 1).
    add_vec(0, 4'b0100, 8'd1, 8'd5, 4'b0100);
    add_vec(0, 4'b0001, 8'd0, 8'd10, 4'b0001);
    add_vec(0, 4'b0010, 8'd0, 8'd10, 4'b0010);
    // ptr=2, requesters 1 and 3: order 3,1,3,1.
    for (int r = 0; r < 2; r++) begin
      add_vec(0, 4'b1010, 8'd20, 8'd7, 4'b1000);
      add_vec(0, 4'b1010, 8'd20, 8'd7, 4'b0010);
    end
    // Contention with a 3-cycle hold; rotation resumes at 3 then 0.
    add_vec(0, 4'hF, 8'd0, 8'd10, 4'b0100);
    for (int i = 0; i < 3; i++) add_vec(1, 4'hF, 8'd0, 8'd10, 4'b0000);
    add_vec(0, 4'hF, 8'd0, 8'd10, 4'b1000);
    add_vec(0, 4'hF, 8'd0, 8'd10, 4'b0001);
    for (int i = 0; i < 3; i++) add_vec(0, 4'h0, 8'd0, 8'd0, 4'b0000);

    // Reset state with every requester valid.
    repeat (3) @(negedge clk_i);
    #1;
    check("reset ready", req_ready_o, 4'b0000);
    check("reset alu_a", alu_a_o, 8'd0);
    check("reset alu_b", alu_b_o, 8'd0);
    check("reset rsp_valid", rsp_valid_o, 1'b0);
    check("reset rsp_id", rsp_id_o, 2'd0);
    check("reset rsp_data", rsp_data_o, 8'd0);
    check("reset issue_cnt", issue_cnt_o, 16'd0);
    @(negedge clk_i);
    req_valid_i = 4'h0;
    reset_ni    = 1'b1;

    foreach (vt[i])
      step(vt[i].hold, vt[i].valid, vt[i].a_base, vt[i].b, vt[i].exp_ready,
           $sformatf("vec%0d", i));

    // Reset one cycle after a transfer: that result must never appear.
    step(0, 4'b0001, 8'd40, 8'd2, 4'b0001, "midflight");
    @(negedge clk_i);
    reset_ni    = 1'b0;
    req_valid_i = 4'h0;
    sb.delete();
    exp_cnt     = '0;
    #1;
    check("midflight rsp_valid", rsp_valid_o, 1'b0);
    check("midflight issue_cnt", issue_cnt_o, 16'd0);
    check("midflight alu_a", alu_a_o, 8'd0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 4'h0, 8'd0, 8'd0, 4'b0000, "post-reset idle");
    step(0, 4'hF, 8'd0, 8'd10, 4'b0001, "post-reset first grant");

    // Saturation: requester 1 alone, one transfer per cycle.
    for (int i = 0; i < 65540; i++) step(0, 4'b0010, 8'd3, 8'd4, 4'b0010, "sat");
    for (int i = 0; i < 4; i++) step(0, 4'h0, 8'd0, 8'd0, 4'b0000, "drain");
    check("saturated issue_cnt", issue_cnt_o, 16'hFFFF);
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
